// File: rtl/msm_window_slicer_pkg.sv
// Shared MSM types: curve point, scalar width, default window width and the
// slice record handed to the bucket stages.
package elliptic_curve_structs;

    localparam int unsigned P_WIDTH      = 256;
    localparam int unsigned SCALAR_WIDTH = 256;

    typedef struct packed {
        logic [P_WIDTH-1:0] x;
        logic [P_WIDTH-1:0] y;
    } curve_point_t;

    localparam int unsigned MSM_WINDOW_BITS = 4;
    localparam int unsigned MSM_NUM_WINDOWS =
        (SCALAR_WIDTH + MSM_WINDOW_BITS - 1) / MSM_WINDOW_BITS;
    localparam int unsigned MSM_WIN_IDX_W =
        (MSM_NUM_WINDOWS > 1) ? $clog2(MSM_NUM_WINDOWS) : 1;

    typedef struct packed {
        logic [MSM_WIN_IDX_W-1:0]   window;
        logic [MSM_WINDOW_BITS-1:0] bucket;
        curve_point_t               point;
    } msm_slice_t;

endpackage

// File: rtl/msm_window_slicer.sv
// Splits each scalar into WINDOW_BITS digits (LSB first) and emits one slice per window.
// Optional MSM_SKIP_ZERO_DIGIT_EN: zero digits advance silently without a handshake.
module msm_window_slicer
    import elliptic_curve_structs::*;
#(
    parameter int unsigned SCALAR_WIDTH = elliptic_curve_structs::SCALAR_WIDTH,
    parameter int unsigned WINDOW_BITS  = MSM_WINDOW_BITS,
    localparam int unsigned NUM_WINDOWS = (SCALAR_WIDTH + WINDOW_BITS - 1) / WINDOW_BITS,
    localparam int unsigned WIN_IDX_W   = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SCALAR_WIDTH-1:0] in_scalar,
    input  curve_point_t            in_point,
    output logic                    out_valid,
    input  logic                    out_ready,
    output curve_point_t            out_point,
    output logic [WIN_IDX_W-1:0]    out_window,
    output logic [WINDOW_BITS-1:0]  out_bucket,
    output logic                    pair_done,
    output logic                    busy
);

    // Padded to whole windows so the top window reads zero-filled upper bits.
    localparam int unsigned PAD_W = NUM_WINDOWS * WINDOW_BITS;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SLICE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PAD_W-1:0]     scalar_q, scalar_d;
    curve_point_t         point_q, point_d;
    logic [WIN_IDX_W-1:0] win_q, win_d;
    logic                 out_valid_q, out_valid_d;
    logic                 pair_done_q, pair_done_d;
    logic                 advance;
    logic                 last_win;

    always_comb begin
        state_d     = state_q;
        scalar_d    = scalar_q;
        point_d     = point_q;
        win_d       = win_q;
        pair_done_d = 1'b0;
        // A silent (zero-digit) window has out_valid low and advances unconditionally.
        advance     = (state_q == SLICE) && (!out_valid_q || out_ready);
        last_win    = (win_q == WIN_IDX_W'(NUM_WINDOWS - 1));

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    scalar_d = PAD_W'(in_scalar);
                    point_d  = in_point;
                    win_d    = '0;
                    state_d  = SLICE;
                end
            end
            SLICE: begin
                if (advance) begin
                    scalar_d = scalar_q >> WINDOW_BITS;
                    if (last_win) begin
                        state_d     = IDLE;
                        pair_done_d = 1'b1;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MSM_SKIP_ZERO_DIGIT_EN
        out_valid_d = (state_d == SLICE) && (scalar_d[WINDOW_BITS-1:0] != '0);
`else
        out_valid_d = (state_d == SLICE);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            scalar_q    <= '0;
            point_q     <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            pair_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            scalar_q    <= scalar_d;
            point_q     <= point_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            pair_done_q <= pair_done_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == SLICE);
    assign out_valid  = out_valid_q;
    assign pair_done  = pair_done_q;
    assign out_point  = point_q;
    assign out_window = win_q;
    assign out_bucket = scalar_q[WINDOW_BITS-1:0];

endmodule

// File: tb/tb_msm_window_slicer.sv
// Directed bench for msm_window_slicer with SCALAR_WIDTH=10, WINDOW_BITS=4 (3 windows).
// Expectations follow MSM_SKIP_ZERO_DIGIT_EN when it is defined.
module tb_msm_window_slicer;
    import elliptic_curve_structs::*;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [9:0]   in_scalar;
    curve_point_t in_point;
    logic         out_valid;
    logic         out_ready;
    curve_point_t out_point;
    logic [1:0]   out_window;
    logic [3:0]   out_bucket;
    logic         pair_done;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int pd_cnt = 0;
    int hs_mark;
    int pd_mark;

    msm_window_slicer #(
        .SCALAR_WIDTH(10),
        .WINDOW_BITS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_scalar (in_scalar),
        .in_point  (in_point),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_point (out_point),
        .out_window(out_window),
        .out_bucket(out_bucket),
        .pair_done (pair_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid && out_ready) hs_cnt++;
        if (pair_done) pd_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_slice(input string tag, input logic [1:0] win, input logic [3:0] bkt);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".window"}, 64'(out_window), 64'(win));
        check({tag, ".bucket"}, 64'(out_bucket), 64'(bkt));
        check({tag, ".px"}, 64'(out_point.x), 64'd6);
        check({tag, ".py"}, 64'(out_point.y), 64'd1);
        step();
    endtask

    task automatic expect_silent(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'd0);
        check({tag, ".busy"}, 64'(busy), 64'd1);
        step();
    endtask

    task automatic expect_done(input string tag);
        check({tag, ".pair_done"}, 64'(pair_done), 64'd1);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".busy"}, 64'(busy), 64'd0);
    endtask

    // Presents k and returns #1 after the accepting edge.
    task automatic send(input logic [9:0] k);
        int n;
        in_scalar = k;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("send.in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_scalar = '0;
        in_point  = '0;
        in_point.x[3:0] = 4'd6;
        in_point.y[0]   = 1'b1;
        out_ready = 1'b1;
        #12;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.pair_done", 64'(pair_done), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.window", 64'(out_window), 64'd0);
        check("rst.bucket", 64'(out_bucket), 64'd0);
        check("rst.px", 64'(out_point.x), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // 1: full-rate slicing of 0x2A5
        send(10'h2A5);
        expect_slice("t1.w0", 2'd0, 4'h5);
        expect_slice("t1.w1", 2'd1, 4'hA);
        expect_slice("t1.w2", 2'd2, 4'h2);
        expect_done("t1.done");
        step();
        check("t1.pd_pulse", 64'(pair_done), 64'd0);

        // 2: backpressure at window 1
        hs_mark = hs_cnt;
        send(10'h2A5);
        expect_slice("t2.w0", 2'd0, 4'h5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) expect_slice("t2.hold", 2'd1, 4'hA);
        out_ready = 1'b1;
        expect_slice("t2.w1", 2'd1, 4'hA);
        expect_slice("t2.w2", 2'd2, 4'h2);
        expect_done("t2.done");
        check("t2.handshakes", 64'(hs_cnt - hs_mark), 64'd3);
        step();

        // 3: 0x0F0 has zero digits in windows 0 and 2
        send(10'h0F0);
`ifdef MSM_SKIP_ZERO_DIGIT_EN
        expect_silent("t3.w0");
        expect_slice("t3.w1", 2'd1, 4'hF);
        expect_silent("t3.w2");
`else
        expect_slice("t3.w0", 2'd0, 4'h0);
        expect_slice("t3.w1", 2'd1, 4'hF);
        expect_slice("t3.w2", 2'd2, 4'h0);
`endif
        expect_done("t3.done");
        step();

        // 4: all-zero scalar
        hs_mark = hs_cnt;
        pd_mark = pd_cnt;
        send(10'h000);
`ifdef MSM_SKIP_ZERO_DIGIT_EN
        for (int i = 0; i < 3; i++) expect_silent("t4.zero");
        check("t4.handshakes", 64'(hs_cnt - hs_mark), 64'd0);
`else
        expect_slice("t4.w0", 2'd0, 4'h0);
        expect_slice("t4.w1", 2'd1, 4'h0);
        expect_slice("t4.w2", 2'd2, 4'h0);
`endif
        expect_done("t4.done");
        step();
        check("t4.pd_count", 64'(pd_cnt - pd_mark), 64'd1);

        // 5: asynchronous reset mid-pair
        pd_mark = pd_cnt;
        send(10'h2A5);
        expect_slice("t5.w0", 2'd0, 4'h5);
        reset = 1'b1;
        #1;
        check("t5.out_valid", 64'(out_valid), 64'd0);
        check("t5.busy", 64'(busy), 64'd0);
        check("t5.in_ready", 64'(in_ready), 64'd1);
        check("t5.pair_done", 64'(pair_done), 64'd0);
        step();
        reset = 1'b0;
        step();
        check("t5.no_pd", 64'(pd_cnt - pd_mark), 64'd0);
        send(10'h3FF);
        expect_slice("t5.n0", 2'd0, 4'hF);
        expect_slice("t5.n1", 2'd1, 4'hF);
        expect_slice("t5.n2", 2'd2, 4'h3);
        expect_done("t5.done");
        step();

        // 6: in_valid held high across two pairs; second waits out the bubble
        pd_mark   = pd_cnt;
        send(10'h001);
        in_valid  = 1'b1;
        in_scalar = 10'h002;
        expect_slice("t6.a0", 2'd0, 4'h1);
`ifdef MSM_SKIP_ZERO_DIGIT_EN
        expect_silent("t6.a1");
        expect_silent("t6.a2");
`else
        expect_slice("t6.a1", 2'd1, 4'h0);
        expect_slice("t6.a2", 2'd2, 4'h0);
`endif
        expect_done("t6.bubble");
        step();
        in_valid = 1'b0;
        expect_slice("t6.b0", 2'd0, 4'h2);
`ifdef MSM_SKIP_ZERO_DIGIT_EN
        expect_silent("t6.b1");
        expect_silent("t6.b2");
`else
        expect_slice("t6.b1", 2'd1, 4'h0);
        expect_slice("t6.b2", 2'd2, 4'h0);
`endif
        expect_done("t6.done");
        step();
        check("t6.pd_count", 64'(pd_cnt - pd_mark), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msm_window_slicer.md
Name: msm_window_slicer

Overview:
- Front end of the Pippenger MSM datapath.
- Accepts one (scalar, curve_point_t) pair at a time and splits the scalar into fixed-width windows, least significant first.
- Emits one (window index, bucket digit, point) slice per window to the downstream bucket accumulator over a valid/ready handshake.
- Sits between the scalar/point input buffer and the per-window bucket-add stage.

Parameters:
- SCALAR_WIDTH, elliptic_curve_structs::SCALAR_WIDTH (256): scalar bit width.
- WINDOW_BITS, 4: bits per window; bucket digit width.
- NUM_WINDOWS (localparam): ceil(SCALAR_WIDTH/WINDOW_BITS).
- WIN_IDX_W (localparam): max(1, $clog2(NUM_WINDOWS)).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input pair valid
- in_ready  output  1  block can accept a pair
- in_scalar  input  SCALAR_WIDTH  scalar k
- in_point  input  2*P_WIDTH  curve_point_t P
- out_valid  output  1  slice valid
- out_ready  input  1  downstream accepts slice
- out_point  output  2*P_WIDTH  curve_point_t, latched P
- out_window  output  WIN_IDX_W  window index of current slice
- out_bucket  output  WINDOW_BITS  digit of k for that window
- pair_done  output  1  one-cycle pulse: pair fully sliced
- busy  output  1  FSM not IDLE

Behaviour:
- Clocking/reset: single clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, pair_done=0, busy=0. All data registers are 0, so out_point, out_window and out_bucket read 0.
- FSM states: IDLE, SLICE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch scalar_reg<=in_scalar, point_reg<=in_point, win_cnt<=0; go to SLICE.
- SLICE:
  - in_ready=0.
  - out_bucket = scalar_reg[WINDOW_BITS-1:0]; out_window = win_cnt; out_point = point_reg.
  - out_valid = 1 (but see optional feature).
- Advance: on out_valid&&out_ready, scalar_reg shifts right by WINDOW_BITS (zero-fill) and win_cnt increments.
  - If win_cnt==NUM_WINDOWS-1, go to IDLE instead.
- Last window: when SCALAR_WIDTH is not a multiple of WINDOW_BITS, the top window is zero-padded in its upper bits.
- Output stability: all out_* are register-driven. They hold stable while out_valid&&!out_ready.
- Latency and throughput:
  - Input handshake at cycle t gives window 0 on out_valid at t+1.
  - One slice per cycle while out_ready=1.
  - A pair takes NUM_WINDOWS cycles minimum, plus one IDLE cycle before the next pair is accepted (in_ready is low during SLICE, so back-to-back pairs have one bubble).
- pair_done: registered. High for exactly the one cycle after the final window is consumed or skipped, coincident with the first IDLE cycle.
- busy = (state==SLICE).
- in_valid while in_ready=0: ignored; upstream holds data.
- Reset mid-SLICE: the in-flight pair is discarded without a pair_done pulse. After deassertion the block is in IDLE, and the next pair starts at window 0.

Optional Feature:
- Macro: MSM_SKIP_ZERO_DIGIT_EN.
- Defined:
  - In SLICE, out_valid = (out_bucket!=0).
  - Zero-digit windows advance (shift/increment) without a handshake, one window per cycle.
  - An all-zero scalar produces no out_valid and takes NUM_WINDOWS cycles, then pair_done.
- Undefined: every window is emitted, including bucket 0.

Decomposition:
- Package elliptic_curve_structs: curve_point_t and P_WIDTH/SCALAR_WIDTH (existing).
- Add to the package: a WINDOW_BITS default constant and a packed msm_slice_t {window, bucket, point} for use by downstream bucket stages.
- Single module; no sub-module is natural (digit extraction is one slice of a shift register).

Test Plan:
All scenarios use SCALAR_WIDTH=10, WINDOW_BITS=4 (NUM_WINDOWS=3), P=(x=6, y=1).
1. k=10'h2A5, out_ready=1 -> out_valid cycles t+1..t+3 with (window,bucket)=(0,5),(1,10),(2,2), point (6,1) each; pair_done at t+4; in_ready high at t+4.
2. k=10'h2A5, out_ready held low 3 cycles at window 1 -> out_window=1, out_bucket=10, out_point stable all 3 cycles; then (2,2); exactly 3 handshakes total.
3. k=10'h0F0 -> without macro: (0,0),(1,15),(2,0). With MSM_SKIP_ZERO_DIGIT_EN: single slice (1,15); pair_done 3 cycles after the first SLICE cycle.
4. k=0 with MSM_SKIP_ZERO_DIGIT_EN -> out_valid never high; pair_done pulses once, 4 cycles after the input handshake.
5. Assert reset one cycle after window 0 handshake -> out_valid=0 and busy=0 immediately (async), no pair_done; new k=10'h3FF then yields (0,15),(1,15),(2,3).
6. in_valid held high with two pairs k=1 then k=2 -> outputs (0,1),(1,0),(2,0), one IDLE bubble, then (0,2),(1,0),(2,0); two pair_done pulses.
